dds_hop_sched: RTL and testbench

Frequency-hop scheduler for the DDS datapath. Holds a table of phase-increment words loaded by the DDS control register file, and steps through them with a programmable dwell time. Each hop is issued as one AXI4-Stream configuration beat to the DDS compiler's config channel. It is the sequencing layer between the AXI4-Lite control registers and the DDS core.

---
 rtl/dds_hop_sched.sv | 190 +++++++++++++++++++
 tb/tb_dds_hop_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_hop_sched.sv
// Frequency-hop scheduler: steps through a phase-increment table with a programmable dwell and
// issues one AXI4-Stream config beat per hop. Define DDS_HOP_RESYNC_EN to add the resync flag bit.
module dds_hop_sched #(
    parameter int DEPTH   = 16,
    parameter int PINC_W  = 32,
    parameter int DWELL_W = 32,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               tbl_we,
    input  logic [AW-1:0]      tbl_addr,
    input  logic [PINC_W-1:0]  tbl_wdata,
    input  logic               enable,
    input  logic               single_shot,
    input  logic [AW:0]        hop_count,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DDS_HOP_RESYNC_EN
    output logic [PINC_W+7:0]  m_axis_config_tdata,
`else
    output logic [PINC_W-1:0]  m_axis_config_tdata,
`endif
    output logic               m_axis_config_tvalid,
    input  logic               m_axis_config_tready,
    output logic               hop_strobe,
    output logic [AW-1:0]      cur_index,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt,
    output logic [2:0]         state_dbg
);

    // Handshake: a beat transfers on any cycle with tvalid=1 and tready=1; once tvalid rises,
    // tvalid and tdata stay constant until that transfer, whatever happens to enable.
    typedef enum logic [2:0] {IDLE, PRIME, ISSUE, DWELL, DONE} state_t;

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    state_t             state, state_nxt;
    logic [PINC_W-1:0]  mem [DEPTH];
    logic [PINC_W-1:0]  pref;
    logic [AW-1:0]      idx;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_eff;
    logic [AW:0]        hop_eff;
    logic [AW:0]        hop_last;
    logic               is_last;
    logic               first_dwell;
    logic               last_q;
    logic               ss_q;
    logic               handshake;
    logic               rd_en;
    logic               start;

    always_comb begin
        hop_eff = hop_count;
        if (hop_count == '0) begin
            hop_eff = (AW+1)'(1);
        end else if (hop_count > DEPTH_V) begin
            hop_eff = DEPTH_V;
        end
    end

    assign hop_last  = hop_eff - (AW+1)'(1);
    assign is_last   = ({1'b0, idx} == hop_last);
    assign dwell_eff = (dwell < DWELL_W'(2)) ? DWELL_W'(2) : dwell;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        handshake            = 1'b0;
        rd_en                = 1'b0;
        start                = 1'b0;
        m_axis_config_tvalid = 1'b0;
        busy                 = 1'b0;
        done                 = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    start     = 1'b1;
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                busy      = 1'b1;
                rd_en     = 1'b1;
                state_nxt = enable ? ISSUE : IDLE;
            end
            ISSUE: begin
                busy                 = 1'b1;
                m_axis_config_tvalid = 1'b1;
                if (m_axis_config_tready) begin
                    handshake = 1'b1;
                    state_nxt = enable ? DWELL : IDLE;
                end
            end
            DWELL: begin
                busy  = 1'b1;
                rd_en = first_dwell;
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (cnt == DWELL_W'(1)) begin
                    state_nxt = (last_q && ss_q) ? DONE : ISSUE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hop_strobe = handshake;
    assign state_dbg  = state;

    // Table RAM: a read and write to the same address in one cycle returns the old entry.
    always_ff @(posedge ACLK) begin
        if (tbl_we) begin
            mem[tbl_addr] <= tbl_wdata;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            idx         <= '0;
            cur_index   <= '0;
            cnt         <= '0;
            pref        <= '0;
            first_dwell <= 1'b0;
            last_q      <= 1'b0;
            ss_q        <= 1'b0;
        end else begin
            first_dwell <= 1'b0;
            if (start) begin
                idx <= '0;
            end
            if (rd_en) begin
                pref <= mem[idx];
            end
            if (handshake) begin
                cur_index   <= idx;
                cnt         <= dwell_eff - DWELL_W'(1);
                first_dwell <= 1'b1;
                ss_q        <= single_shot;
                last_q      <= is_last;
                idx         <= is_last ? '0 : idx + AW'(1);
            end else if (state == DWELL) begin
                cnt <= cnt - DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stall_cnt <= '0;
        end else if (m_axis_config_tvalid && !m_axis_config_tready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

`ifdef DDS_HOP_RESYNC_EN
    logic resync;

    // Flag the first beat of a run and every index-0 beat that follows a wrap.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            resync <= 1'b0;
        end else if (start) begin
            resync <= 1'b1;
        end else if (handshake) begin
            resync <= is_last;
        end
    end

    assign m_axis_config_tdata = {7'b0, resync, pref};
`else
    assign m_axis_config_tdata = pref;
`endif

endmodule

// File: tb/tb_dds_hop_sched.sv
// Bench for dds_hop_sched: randomized hop runs against a table-walk model, with a scoreboard
// monitor checking beat data, issue timing, cur_index, hop_strobe and stall_cnt.
module tb_dds_hop_sched;
  localparam int DEPTH = 16;
  localparam int PINC_W = 32;
  localparam int DWELL_W = 32;
  localparam int AW = 4;
`ifdef DDS_HOP_RESYNC_EN
  localparam int TDW = PINC_W + 8;
`else
  localparam int TDW = PINC_W;
`endif

  logic ACLK;
  logic ARESET;
  logic tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [PINC_W-1:0] tbl_wdata;
  logic enable;
  logic single_shot;
  logic [AW:0] hop_count;
  logic [DWELL_W-1:0] dwell;
  logic [TDW-1:0] m_axis_config_tdata;
  logic m_axis_config_tvalid;
  logic m_axis_config_tready;
  logic hop_strobe;
  logic [AW-1:0] cur_index;
  logic busy;
  logic done;
  logic [15:0] stall_cnt;
  logic [2:0] state_dbg;

  dds_hop_sched #(.DEPTH(DEPTH), .PINC_W(PINC_W), .DWELL_W(DWELL_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .enable(enable), .single_shot(single_shot), .hop_count(hop_count), .dwell(dwell),
    .m_axis_config_tdata(m_axis_config_tdata), .m_axis_config_tvalid(m_axis_config_tvalid),
    .m_axis_config_tready(m_axis_config_tready), .hop_strobe(hop_strobe), .cur_index(cur_index),
    .busy(busy), .done(done), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge ACLK);
      cyc++;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [TDW-1:0] exp_q[$];
  int gap_q[$];
  int idx_q[$];
  logic [PINC_W-1:0] tbl_m [DEPTH];
  int hs_total = 0;
  int last_hs_cyc = 0;
  bit bp_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int hop_eff_f(input int hc);
    if (hc == 0) return 1;
    if (hc > DEPTH) return DEPTH;
    return hc;
  endfunction

  // Beat k of a run walks the table modulo the active length; index-0 beats carry resync.
  function automatic logic [TDW-1:0] model_beat(input int k, input int he);
    logic [TDW-1:0] v;
    int i;
    i = k % he;
    v = '0;
    v[PINC_W-1:0] = tbl_m[i];
`ifdef DDS_HOP_RESYNC_EN
    v[PINC_W] = (i == 0);
`endif
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ACLK);
    #1;
    if (bp_on) m_axis_config_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic tbl_write(input int a, input logic [PINC_W-1:0] d);
    tbl_we = 1'b1;
    tbl_addr = a[AW-1:0];
    tbl_wdata = d;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (hs_total < target && n < budget) begin
      step();
      n++;
    end
    if (hs_total < target) chk("hs_timeout", hs_total, target);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!m_axis_config_tvalid && n < budget) begin
      step();
      n++;
    end
    if (!m_axis_config_tvalid) chk("valid_timeout", m_axis_config_tvalid, 1);
  endtask

  task automatic push_run(input int he, input int d, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      exp_q.push_back(model_beat(k, he));
      gap_q.push_back(k == 0 ? 2 : d);
      idx_q.push_back(k % he);
    end
  endtask

  task automatic flush_q();
    exp_q.delete();
    gap_q.delete();
    idx_q.delete();
  endtask

  task automatic run_seq(input int hc, input int dw, input bit ss, input int nbeats);
    int he, d, base, n, nb;
    he = hop_eff_f(hc);
    d = (dw < 2) ? 2 : dw;
    nb = ss ? he : nbeats;
    base = hs_total;
    hop_count = hc[AW:0];
    dwell = dw;
    single_shot = ss;
    push_run(he, d, nb);
    enable = 1'b1;
    wait_hs(base + nb, nb * (d + 40) + 20);
    if (ss) begin
      n = 0;
      while (!done && n < d + 40) begin
        step();
        n++;
      end
      chk("done_latency", cyc - last_hs_cyc, d);
      chk("busy_in_done", busy, 0);
      chk("tvalid_in_done", m_axis_config_tvalid, 0);
    end
    enable = 1'b0;
    step();
    if (ss) chk("done_clear", done, 0);
    repeat (4) step();
    chk("busy_after_stop", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    flush_q();
  endtask

  // ---------------- monitor ----------------
  initial begin
    int stall_m, ref_cyc, pres_gap, pend_idx;
    bit prev_valid, prev_stall, prev_en, pend;
    logic [TDW-1:0] prev_data;
    stall_m = 0; ref_cyc = 0; pres_gap = 0; pend_idx = 0;
    prev_valid = 0; prev_stall = 0; prev_en = 0; pend = 0; prev_data = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        stall_m = 0;
        prev_valid = 0;
        prev_stall = 0;
        prev_en = 0;
        pend = 0;
      end else begin
        chk("stall_cnt_track", stall_cnt, stall_m);
        chk("hop_strobe", hop_strobe, m_axis_config_tvalid && m_axis_config_tready);
        if (pend) begin
          chk("cur_index", cur_index, pend_idx);
          pend = 0;
        end
        if (enable && !prev_en) ref_cyc = cyc;
        prev_en = enable;
        if (m_axis_config_tvalid && !prev_valid) pres_gap = cyc - ref_cyc;
        if (m_axis_config_tvalid && prev_stall) chk("tdata_stable", m_axis_config_tdata, prev_data);
        if (m_axis_config_tvalid && m_axis_config_tready) begin
          hs_total++;
          last_hs_cyc = cyc;
          ref_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=0x%0h required=none t=%0t", m_axis_config_tdata, $time);
          end else begin
            chk("beat_data", m_axis_config_tdata, exp_q.pop_front());
            chk("beat_gap", pres_gap, gap_q.pop_front());
            pend = 1;
            pend_idx = idx_q.pop_front();
          end
        end
        if (m_axis_config_tvalid && !m_axis_config_tready && stall_m != 65535) stall_m++;
        prev_valid = m_axis_config_tvalid;
        prev_stall = m_axis_config_tvalid && !m_axis_config_tready;
        prev_data = m_axis_config_tdata;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int hc, dw, a, base;
    bit ss;
    ARESET = 1'b1; enable = 1'b0; single_shot = 1'b0; hop_count = '0; dwell = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0; m_axis_config_tready = 1'b1;
    repeat (3) step();
    ARESET = 1'b0;
    chk("rst_tvalid", m_axis_config_tvalid, 0);
    chk("rst_tdata", m_axis_config_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_index", cur_index, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    for (int i = 0; i < DEPTH; i++) begin
      tbl_m[i] = (i < 4) ? PINC_W'((i + 1) * 32'h100) : $urandom;
      tbl_write(i, tbl_m[i]);
    end

    run_seq(4, 10, 0, 10);
    run_seq(4, 10, 1, 0);
    run_seq(4, 10, 1, 0);
    run_seq(4, 0, 0, 6);
    run_seq(4, 1, 0, 6);
    run_seq(0, 3, 0, 5);
    run_seq(DEPTH + 5, 2, 0, 2 * DEPTH + 2);
    run_seq(2, 3, 0, 6);

    bp_on = 1;
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, DEPTH - 1);
        tbl_m[a] = $urandom;
        tbl_write(a, tbl_m[a]);
      end
      hc = $urandom_range(0, 2 * DEPTH - 1);
      dw = $urandom_range(0, 6);
      ss = 1'($urandom_range(0, 1));
      run_seq(hc, dw, ss, $urandom_range(1, 12));
    end
    bp_on = 0;
    m_axis_config_tready = 1'b1;
    step();

    // Reset in the middle of a dwell, then confirm the table survived.
    hop_count = 5'd4; dwell = 10; single_shot = 1'b0;
    base = hs_total;
    push_run(4, 10, 2);
    enable = 1'b1;
    wait_hs(base + 2, 100);
    repeat (3) step();
    ARESET = 1'b1;
    enable = 1'b0;
    step();
    ARESET = 1'b0;
    flush_q();
    chk("mid_rst_tvalid", m_axis_config_tvalid, 0);
    chk("mid_rst_tdata", m_axis_config_tdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_strobe", hop_strobe, 0);
    chk("mid_rst_cur_index", cur_index, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
    step();
    run_seq(4, 10, 0, 3);

    // Seven-cycle stall on the 0x200 beat, then drop enable during a stall on 0x300.
    hop_count = 5'd4; dwell = 10; single_shot = 1'b0;
    base = hs_total;
    push_run(4, 10, 3);
    enable = 1'b1;
    wait_hs(base + 1, 100);
    m_axis_config_tready = 1'b0;
    wait_valid(100);
    repeat (7) step();
    m_axis_config_tready = 1'b1;
    wait_hs(base + 2, 20);
    chk("stall_cnt_7", stall_cnt, 7);
    m_axis_config_tready = 1'b0;
    wait_valid(100);
    enable = 1'b0;
    repeat (3) step();
    m_axis_config_tready = 1'b1;
    wait_hs(base + 3, 20);
    chk("stop_busy", busy, 0);
    chk("stop_tvalid", m_axis_config_tvalid, 0);
    repeat (15) step();
    chk("stop_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
